alu_slice_seq: RTL and testbench

Multi-cycle sequencer that executes a wide ALU operation (ADDU, SUBU, AND, XOR) on a narrow ALU slice, processing one slice per cycle from least to most significant with carry chaining. It sits between an instruction-issue front end and the narrow ALU datapath. It accepts one command per valid/ready handshake and returns a registered result with carry and zero flags through a second valid/ready handshake.

---
 rtl/alu_slice_seq_pkg.sv | 32 +++
 rtl/alu_slice_seq_slice.sv | 42 ++++
 rtl/alu_slice_seq.sv | 145 ++++++++++++++
 tb/tb_alu_slice_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_slice_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : definitions (package)
//  Description : Shared types for the sliced ALU sequencer: operation
//                mnemonics, sequencer state encoding and the slice-0
//                carry-in rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package definitions;

  // Operation encoding; all four 2-bit codes are defined.
  typedef enum logic [1:0] {
    ADDU = 2'd0,
    SUBU = 2'd1,
    AND  = 2'd2,
    XOR  = 2'd3
  } op_mne;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Carry into the least significant slice: subtraction is a + ~b + 1.
  function automatic logic first_cin(input op_mne op);
    return (op == SUBU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_slice_seq_slice.sv
`default_nettype none
// ============================================================================
//  Module      : alu_slice
//  Description : Combinational SLICE_W-bit ALU slice. Arithmetic ops produce
//                a carry-out for chaining; logic ops force carry-out to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_slice
  import definitions::*;
#(
  parameter int SLICE_W = 8
) (
  input  op_mne              op,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] y,
  output logic               cout
);

  logic [SLICE_W-1:0] w_b_eff;
  logic [SLICE_W:0]   w_sum;

  // Shared adder (b inverted for SUBU) plus bitwise ops, selected by op.
  always_comb begin
    w_b_eff = (op == SUBU) ? ~b : b;
    w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{SLICE_W{1'b0}}, cin};
    y       = w_sum[SLICE_W-1:0];
    cout    = 1'b0;
    case (op)
      ADDU, SUBU: begin
        y    = w_sum[SLICE_W-1:0];
        cout = w_sum[SLICE_W];
      end
      AND:     y = a & b;
      XOR:     y = a ^ b;
      default: y = w_sum[SLICE_W-1:0];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_slice_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_slice_seq
//  Description : Multi-cycle wide ALU built on one narrow slice. Captures a
//                command, walks the slices LSB first chaining the carry, then
//                presents result/carry/zero until the consumer accepts.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_slice_seq
  import definitions::*;
#(
  parameter int SLICE_W    = 8,
  parameter int NUM_SLICES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  op_mne                         in_op,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_a,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] out_result,
  output logic                          out_carry,
  output logic                          out_zero,
  output logic                          busy
);

  localparam int DATA_W = SLICE_W * NUM_SLICES;
  // Counter must reach NUM_SLICES without wrapping.
  localparam int CNT_W  = $clog2(NUM_SLICES + 1);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  seq_state_e         state_q,  state_d;
  op_mne              op_q,     op_d;
  logic [DATA_W-1:0]  a_q,      a_d;
  logic [DATA_W-1:0]  b_q,      b_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               carry_q,  carry_d;
  logic               zero_q,   zero_d;

  logic [IDX_W-1:0]   w_base;
  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_y;
  logic               w_cin;
  logic               w_cout;
  logic               w_last;

  // Select the current slice of each operand and its carry-in.
  always_comb begin
    w_base    = IDX_W'(cnt_q * SLICE_W);
    w_a_slice = a_q[w_base +: SLICE_W];
    w_b_slice = b_q[w_base +: SLICE_W];
    w_cin     = (cnt_q == '0) ? first_cin(op_q) : carry_q;
    w_last    = (cnt_q == CNT_W'(NUM_SLICES - 1));
  end

  alu_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .op   (op_q),
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (w_cin),
    .y    (w_y),
    .cout (w_cout)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[w_base +: SLICE_W] = w_y;
        carry_d = w_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (w_last) begin
          // Zero flag taken from the fully assembled result.
          zero_d  = (result_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= ADDU;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_slice_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_slice_seq
//  Description : Directed self-checking bench for alu_slice_seq (16-bit data,
//                two 8-bit slices).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_slice_seq;
  import definitions::*;

  localparam int SW = 8;
  localparam int NS = 2;
  localparam int W  = SW * NS;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  op_mne         in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_carry;
  logic          out_zero;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Directed arithmetic vectors with hand-computed results.
  localparam op_mne        AR_OP [4] = '{ADDU, ADDU, SUBU, SUBU};
  localparam logic [W-1:0] AR_A  [4] = '{16'h00FF, 16'hFFFF, 16'h0001, 16'h1000};
  localparam logic [W-1:0] AR_B  [4] = '{16'h0001, 16'h0001, 16'h0002, 16'h0001};
  localparam logic [W-1:0] AR_R  [4] = '{16'h0100, 16'h0000, 16'hFFFF, 16'h0FFF};
  localparam logic         AR_C  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic         AR_Z  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  // Directed logic vectors.
  localparam op_mne        LG_OP [2] = '{AND, XOR};
  localparam logic [W-1:0] LG_A  [2] = '{16'hF0F0, 16'hAAAA};
  localparam logic [W-1:0] LG_B  [2] = '{16'hFF00, 16'hAAAA};
  localparam logic [W-1:0] LG_R  [2] = '{16'hF000, 16'h0000};
  localparam logic         LG_Z  [2] = '{1'b0, 1'b1};

  alu_slice_seq #(
    .SLICE_W    (SW),
    .NUM_SLICES (NS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-width reference: {carry, result}.
  function automatic logic [W:0] model(input op_mne op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      ADDU:    return {1'b0, a} + {1'b0, b};
      SUBU:    return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      AND:     return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Present a command for one edge, then count edges until out_valid.
  task automatic send(input op_mne op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Accept the pending result for one cycle.
  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (out_result !== '0)   begin n_fail++; $display("FAIL reset out_result: got %h expected 0000", out_result); end
    n_checks++; if (out_carry !== 1'b0)  begin n_fail++; $display("FAIL reset out_carry: got %b expected 0", out_carry); end
    n_checks++; if (out_zero !== 1'b0)   begin n_fail++; $display("FAIL reset out_zero: got %b expected 0", out_zero); end
    reset = 1'b0;
  endtask

  task automatic test_arith();
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(AR_OP[i], AR_A[i], AR_B[i], lat);
      n_checks++; if (lat !== NS)              begin n_fail++; $display("FAIL arith[%0d] latency: got %0d expected %0d", i, lat, NS); end
      n_checks++; if (out_result !== AR_R[i])  begin n_fail++; $display("FAIL arith[%0d] result: got %h expected %h", i, out_result, AR_R[i]); end
      n_checks++; if (out_carry !== AR_C[i])   begin n_fail++; $display("FAIL arith[%0d] carry: got %b expected %b", i, out_carry, AR_C[i]); end
      n_checks++; if (out_zero !== AR_Z[i])    begin n_fail++; $display("FAIL arith[%0d] zero: got %b expected %b", i, out_zero, AR_Z[i]); end
      release_result();
    end
  endtask

  task automatic test_logic();
    int lat;
    for (int i = 0; i < 2; i++) begin
      send(LG_OP[i], LG_A[i], LG_B[i], lat);
      n_checks++; if (lat !== NS)              begin n_fail++; $display("FAIL logic[%0d] latency: got %0d expected %0d", i, lat, NS); end
      n_checks++; if (out_result !== LG_R[i])  begin n_fail++; $display("FAIL logic[%0d] result: got %h expected %h", i, out_result, LG_R[i]); end
      n_checks++; if (out_carry !== 1'b0)      begin n_fail++; $display("FAIL logic[%0d] carry: got %b expected 0", i, out_carry); end
      n_checks++; if (out_zero !== LG_Z[i])    begin n_fail++; $display("FAIL logic[%0d] zero: got %b expected %b", i, out_zero, LG_Z[i]); end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(ADDU, 16'h7FFF, 16'h0001, lat);
    n_checks++; if (lat !== NS) begin n_fail++; $display("FAIL bp latency: got %0d expected %0d", lat, NS); end
    for (int i = 0; i < 5; i++) begin
      in_op    = SUBU;
      in_a     = 16'hFFFF - 16'(i);
      in_b     = 16'h0003;
      in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1)      begin n_fail++; $display("FAIL bp[%0d] out_valid: got %b expected 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0)       begin n_fail++; $display("FAIL bp[%0d] in_ready: got %b expected 0", i, in_ready); end
      n_checks++; if (out_result !== 16'h8000) begin n_fail++; $display("FAIL bp[%0d] result: got %h expected 8000", i, out_result); end
      n_checks++; if (out_carry !== 1'b0 || out_zero !== 1'b0) begin n_fail++; $display("FAIL bp[%0d] flags: got c=%b z=%b expected c=0 z=0", i, out_carry, out_zero); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0)      begin n_fail++; $display("FAIL bp release out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1)       begin n_fail++; $display("FAIL bp release in_ready: got %b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL bp release busy: got %b expected 0", busy); end
    n_checks++; if (out_result !== 16'h8000) begin n_fail++; $display("FAIL bp release result: got %h expected 8000", out_result); end
  endtask

  task automatic test_reset_in_run();
    int  lat;
    logic saw_valid;
    in_op    = ADDU;
    in_a     = 16'h00FF;
    in_b     = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_run busy after accept: got %b expected 1", busy); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_run after slice0: got busy=%b valid=%b expected busy=1 valid=0", busy, out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_run busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_run in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_result !== '0)   begin n_fail++; $display("FAIL rst_run result: got %h expected 0000", out_result); end
    saw_valid = out_valid;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | out_valid;
    end
    n_checks++; if (saw_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_run stray out_valid: got %b expected 0", saw_valid); end
    send(ADDU, 16'h0002, 16'h0003, lat);
    n_checks++; if (lat !== NS)              begin n_fail++; $display("FAIL rst_run post latency: got %0d expected %0d", lat, NS); end
    n_checks++; if (out_result !== 16'h0005) begin n_fail++; $display("FAIL rst_run post result: got %h expected 0005", out_result); end
    n_checks++; if (out_carry !== 1'b0 || out_zero !== 1'b0) begin n_fail++; $display("FAIL rst_run post flags: got c=%b z=%b expected c=0 z=0", out_carry, out_zero); end
    release_result();
  endtask

  task automatic test_back_to_back();
    op_mne        ops [4];
    logic [W-1:0] as  [4];
    logic [W-1:0] bs  [4];
    int           acc [4];
    int           edges;
    int           guard;
    logic [W:0]   exp;
    edges = 0;
    for (int i = 0; i < 4; i++) begin
      ops[i] = op_mne'($urandom_range(0, 3));
      as[i]  = W'($urandom);
      bs[i]  = W'($urandom);
    end
    out_ready = 1'b1;
    in_op     = ops[0];
    in_a      = as[0];
    in_b      = bs[0];
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(posedge clk); #1;
        edges++;
        guard++;
      end
      @(posedge clk); #1;
      edges++;
      acc[i]   = edges;
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 20) begin
        @(posedge clk); #1;
        edges++;
        guard++;
      end
      exp = model(ops[i], as[i], bs[i]);
      n_checks++; if (out_valid !== 1'b1)        begin n_fail++; $display("FAIL b2b[%0d] out_valid: got %b expected 1", i, out_valid); end
      n_checks++; if (out_result !== exp[W-1:0]) begin n_fail++; $display("FAIL b2b[%0d] result op=%0d a=%h b=%h: got %h expected %h", i, ops[i], as[i], bs[i], out_result, exp[W-1:0]); end
      n_checks++; if (out_carry !== exp[W])      begin n_fail++; $display("FAIL b2b[%0d] carry: got %b expected %b", i, out_carry, exp[W]); end
      n_checks++; if (out_zero !== (exp[W-1:0] == '0)) begin n_fail++; $display("FAIL b2b[%0d] zero: got %b expected %b", i, out_zero, (exp[W-1:0] == '0)); end
      if (i < 3) begin
        in_op    = ops[i+1];
        in_a     = as[i+1];
        in_b     = bs[i+1];
        in_valid = 1'b1;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (acc[i] - acc[i-1] !== NS + 2) begin n_fail++; $display("FAIL b2b spacing[%0d]: got %0d expected %0d", i, acc[i] - acc[i-1], NS + 2); end
    end
  endtask

  // Hard stop in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Test sequence.
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = ADDU;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    test_reset();
    test_arith();
    test_logic();
    test_backpressure();
    test_reset_in_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
